oam_dma_ctrl: RTL

Sprite DMA controller sitting between the CPU core and the CPU-side bus mux in front of the 2KB work RAM and the PPU register file. A CPU write of page value P to $4014 halts the CPU and makes the block the bus master. It then copies 256 bytes from addresses P00–PFF (normally work RAM) to PPU register $2004 (OAMDATA) as alternating read/write cycles. When the copy is done, it returns the bus to the CPU.

---
 rtl/nes_bus_pkg.sv | 15 +
 rtl/oam_dma_ctrl.sv | 101 ++++++++++
 2 files changed

// File: rtl/nes_bus_pkg.sv
// rtl/nes_bus_pkg.sv - shared CPU bus addresses and sprite DMA state encoding
package nes_bus_pkg;

  localparam logic [15:0] OAM_DMA_REG_ADDR = 16'h4014;
  localparam logic [15:0] OAM_DATA_ADDR    = 16'h2004;

  typedef enum logic [2:0] {
    IDLE,
    HALT,
    ALIGN,
    READ,
    WRITE
  } oam_dma_state_t;

endpackage

// File: rtl/oam_dma_ctrl.sv
// rtl/oam_dma_ctrl.sv - sprite DMA: copies page P00-PFF to OAMDATA while the CPU is halted
// Optional OAM_DMA_ALIGN_EN adds a cycle-parity flop so reads start on even cycles.
module oam_dma_ctrl
  import nes_bus_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic [15:0] cpu_a_in,
  input  logic [7:0]  cpu_d_in,
  input  logic        cpu_r_nw_in,
  input  logic [7:0]  bus_d_in,
  output logic        cpu_rdy_out,
  output logic        dma_active_out,
  output logic [15:0] dma_a_out,
  output logic [7:0]  dma_d_out,
  output logic        dma_r_nw_out,
  output logic        dma_busy_out
);

  oam_dma_state_t state_q, state_d;
  logic [7:0]  page_q, idx_q, idx_d, data_q;
  logic        rdy_q, active_q, busy_q, r_nw_q;
  logic [15:0] a_q;
  logic        trigger;
  logic        align_req;

`ifdef OAM_DMA_ALIGN_EN
  logic cyc_par_q;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) cyc_par_q <= 1'b0;
    else           cyc_par_q <= ~cyc_par_q;
  end

  assign align_req = cyc_par_q;
`else
  assign align_req = 1'b0;
`endif

  assign trigger = (cpu_a_in == OAM_DMA_REG_ADDR) && !cpu_r_nw_in;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE:  if (trigger) begin
               state_d = HALT;
               idx_d   = 8'h00;
             end
      // RDY only stalls a 6502 on read cycles, so wait for the CPU to read.
      HALT:  if (cpu_r_nw_in) state_d = align_req ? ALIGN : READ;
      ALIGN: state_d = READ;
      READ:  state_d = WRITE;
      WRITE: if (idx_q == 8'hFF) begin
               state_d = IDLE;
             end else begin
               state_d = READ;
               idx_d   = idx_q + 8'h01;
             end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they change cleanly at the edge.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q  <= IDLE;
      page_q   <= 8'h00;
      idx_q    <= 8'h00;
      data_q   <= 8'h00;
      rdy_q    <= 1'b1;
      active_q <= 1'b0;
      busy_q   <= 1'b0;
      r_nw_q   <= 1'b1;
      a_q      <= 16'h0000;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      if (state_q == IDLE && trigger) page_q <= cpu_d_in;
      if (state_q == WRITE)           data_q <= bus_d_in;
      rdy_q    <= (state_d == IDLE);
      busy_q   <= (state_d != IDLE);
      active_q <= (state_d == READ) || (state_d == WRITE);
      r_nw_q   <= (state_d != WRITE);
      case (state_d)
        READ:    a_q <= {page_q, idx_d};
        WRITE:   a_q <= OAM_DATA_ADDR;
        default: a_q <= 16'h0000;
      endcase
    end
  end

  assign cpu_rdy_out    = rdy_q;
  assign dma_active_out = active_q;
  assign dma_busy_out   = busy_q;
  assign dma_r_nw_out   = r_nw_q;
  assign dma_a_out      = a_q;
  // Read data arrives one cycle after its address, so WRITE forwards it directly.
  assign dma_d_out      = (state_q == WRITE) ? bus_d_in : data_q;

endmodule
